i2s_rx_unit: RTL
================

// Module: i2s_rx_unit
// PURPOSE
//   I2S receiver/deserializer downstream of the audioport I2S transmitter, same clk domain.
//   Monitors ws/sck/sdo, recovers 24-bit left/right words and emits one stereo pair per frame.
//   Serves as the loopback checker in audioport benches and as the codec-side model in system sims.
// PARAMETERS
//   DATA_BITS     24    bits per channel word, MSB first
//   TIMEOUT_CYC   1024  clk cycles with no sck rising edge before the link is declared idle
// PORTS
//   clk          in   1          system clock; all logic on rising edge
//   rst          in   1          synchronous, active-high reset
//   ws_in        in   1          word select: 0 = left (audio0), 1 = right (audio1)
//   sck_in       in   1          serial bit clock, generated in the clk domain
//   sdo_in       in   1          serial data
//   audio0_out   out  DATA_BITS  last complete left word
//   audio1_out   out  DATA_BITS  last complete right word
//   valid_out    out  1          1-cycle pulse: new audio0/audio1 pair is valid
//   active_out   out  1          1 while the receiver is frame-locked
//   frame_err_out out 1          1-cycle pulse: word with bit count != DATA_BITS discarded
// BEHAVIOUR
//   Reset: all outputs 0, shift reg 0, bit_cnt 0, state HUNT. rst mid-frame aborts the frame; no partial output.
//   Edge detect: sck_q <= sck_in; rise = sck_in & ~sck_q. ws_in and sdo_in are sampled only in rise cycles.
//   Format (Philips): ws toggles one sck before MSB; the bit sampled on the rise where ws differs from
//     ws_q (ws at previous rise) is the LSB of the word for channel ws_q.
//   On each rise: shreg <= {shreg[DATA_BITS-2:0], sdo_in}; bit_cnt increments, saturating at DATA_BITS+1.
//   Boundary = rise with ws_in != ws_q. Word = {shreg[DATA_BITS-2:0], sdo_in}; bit_cnt+1 must equal DATA_BITS.
//     Then bit_cnt <= 0 and ws_q <= ws_in.
//   States:
//     HUNT   : at first boundary, discard word, go LEFT if ws_in==0, RIGHT if ws_in==1. active_out=0.
//     LEFT   : at boundary, if count ok -> latch left_hold, go RIGHT; else err, go HUNT.
//     RIGHT  : at boundary, if count ok and left_hold valid -> audio0_out<=left_hold, audio1_out<=word,
//              valid_out pulse; go LEFT. Bad count -> err, go HUNT.
//   active_out = 1 in LEFT/RIGHT, 0 in HUNT.
//   Latency: valid_out and audio*_out update in the clk cycle after the rise cycle carrying the right LSB.
//   audio*_out hold their value between pairs; they are not cleared on error or timeout.
//   Error: frame_err_out pulses 1 cycle after the offending rise; valid_out never pulses in the same cycle.
//   Timeout: idle counter clears on every rise; at TIMEOUT_CYC -> state HUNT, left_hold invalid, bit_cnt 0.
//     No error pulse on timeout. Timeout and a rise in the same cycle: the rise wins.
//   A right word arriving first after HUNT (no left_hold) is dropped silently; first pair follows the next left.
//   ws toggling with sck static is ignored. Only rise cycles count.
// STRUCTURE
//   audioport_pkg additions: I2S_DATA_BITS = 24, I2S_RX_TIMEOUT = 1024,
//     typedef enum logic [1:0] {RX_HUNT, RX_LEFT, RX_RIGHT} i2s_rx_state_t.
//   One sub-module: i2s_rx_shifter, covering sck edge detect, shift register, bit counter and boundary/count_ok flags.
//   The parent holds the FSM, hold registers, timeout counter and outputs.
// TESTING
//   1 Reset mid-frame (rst high for 2 clk) -> all outputs 0 next cycle; no valid_out until 2 full frames re-lock.
//   2 Loopback from the I2S transmitter: L=24'h123456, R=24'hABCDEF for 4 frames -> 3 valid_out pulses
//     after first lock, audio0_out=24'h123456, audio1_out=24'hABCDEF; 1 valid per 48 sck.
//   3 Extremes: L=24'h800000, R=24'h7FFFFF, then 24'h000001/24'hFFFFFF -> bit-exact, MSB-first order.
//   4 Short word (23 bits, left) -> frame_err_out 1 pulse, active_out 0, no valid; relock after 2 good frames.
//   5 Long word (25 bits, right) -> frame_err_out, bit_cnt saturates, no wrap-induced false valid.
//   6 Stop sck for TIMEOUT_CYC clk -> active_out falls exactly at cycle 1024, audio*_out held, no err pulse.

Source files
------------

// File: rtl/i2s_rx_unit_pkg.sv
// Shared constants and state encoding for the I2S receive path.
package i2s_rx_unit_pkg;

  localparam int unsigned I2S_DATA_BITS  = 24;
  localparam int unsigned I2S_RX_TIMEOUT = 1024;

  typedef enum logic [1:0] {RX_HUNT, RX_LEFT, RX_RIGHT} i2s_rx_state_t;

endpackage

// File: rtl/i2s_rx_shifter.sv
// I2S bit-level front end: sck rise detect, MSB-first shift register,
// saturating bit counter and word-boundary / count-check flags.
module i2s_rx_shifter
  import i2s_rx_unit_pkg::*;
#(
  parameter int unsigned DATA_BITS = I2S_DATA_BITS
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 sck_i,
  input  logic                 ws_i,
  input  logic                 sdo_i,
  input  logic                 clr_i,
  output logic                 rise_o,
  output logic                 boundary_o,
  output logic                 count_ok_o,
  output logic [DATA_BITS-1:0] word_o
);

  localparam int unsigned CW = $clog2(DATA_BITS + 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(DATA_BITS + 1);

  logic                 sck_q;
  logic                 ws_q;
  logic                 seen_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;

  assign rise_o = sck_i & ~sck_q;
  // ws_q is meaningless until one rise has been seen after reset, so no
  // boundary can be declared on that first rise.
  assign boundary_o = rise_o & seen_q & (ws_i != ws_q);
  assign count_ok_o = (bit_cnt_q == CW'(DATA_BITS - 1));
  assign word_o     = {shreg_q[DATA_BITS-2:0], sdo_i};

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (rise_o) begin
      if (boundary_o)
        bit_cnt_d = '0;
      else if (bit_cnt_q != CNT_MAX)
        bit_cnt_d = bit_cnt_q + CW'(1);
    end else if (clr_i) begin
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_q     <= 1'b0;
      ws_q      <= 1'b0;
      seen_q    <= 1'b0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      sck_q     <= sck_i;
      bit_cnt_q <= bit_cnt_d;
      if (rise_o) begin
        shreg_q <= word_o;
        ws_q    <= ws_i;
        seen_q  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2s_rx_unit.sv
// I2S receiver: frame-lock FSM, left-word hold, idle timeout and
// registered stereo-pair / error outputs.
module i2s_rx_unit
  import i2s_rx_unit_pkg::*;
#(
  parameter int unsigned DATA_BITS   = I2S_DATA_BITS,
  parameter int unsigned TIMEOUT_CYC = I2S_RX_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ws_in,
  input  logic                 sck_in,
  input  logic                 sdo_in,
  output logic [DATA_BITS-1:0] audio0_out,
  output logic [DATA_BITS-1:0] audio1_out,
  output logic                 valid_out,
  output logic                 active_out,
  output logic                 frame_err_out
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYC - 1);

  i2s_rx_state_t        state_q, state_d;
  logic [DATA_BITS-1:0] left_hold_q, left_hold_d;
  logic                 left_vld_q, left_vld_d;
  logic [DATA_BITS-1:0] audio0_q, audio0_d;
  logic [DATA_BITS-1:0] audio1_q, audio1_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic [TW-1:0]        idle_q, idle_d;

  logic                 rise, boundary, count_ok, timeout;
  logic [DATA_BITS-1:0] word;

  i2s_rx_shifter #(.DATA_BITS(DATA_BITS)) u_shifter (
    .clk_i      (clk),
    .rst_i      (rst),
    .sck_i      (sck_in),
    .ws_i       (ws_in),
    .sdo_i      (sdo_in),
    .clr_i      (timeout),
    .rise_o     (rise),
    .boundary_o (boundary),
    .count_ok_o (count_ok),
    .word_o     (word)
  );

  // Idle counter saturates, so timeout stays asserted while the link is quiet.
  assign timeout = ~rise & (idle_q == IDLE_LAST);

  always_comb begin
    state_d     = state_q;
    left_hold_d = left_hold_q;
    left_vld_d  = left_vld_q;
    audio0_d    = audio0_q;
    audio1_d    = audio1_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    idle_d      = rise ? '0 : (timeout ? idle_q : idle_q + TW'(1));

    if (timeout) begin
      state_d    = RX_HUNT;
      left_vld_d = 1'b0;
    end else if (boundary) begin
      case (state_q)
        RX_HUNT: state_d = ws_in ? RX_RIGHT : RX_LEFT;
        RX_LEFT: begin
          if (count_ok) begin
            left_hold_d = word;
            left_vld_d  = 1'b1;
            state_d     = RX_RIGHT;
          end else begin
            err_d      = 1'b1;
            left_vld_d = 1'b0;
            state_d    = RX_HUNT;
          end
        end
        RX_RIGHT: begin
          if (count_ok) begin
            if (left_vld_q) begin
              audio0_d = left_hold_q;
              audio1_d = word;
              valid_d  = 1'b1;
            end
            left_vld_d = 1'b0;
            state_d    = RX_LEFT;
          end else begin
            err_d      = 1'b1;
            left_vld_d = 1'b0;
            state_d    = RX_HUNT;
          end
        end
        default: state_d = RX_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RX_HUNT;
      left_hold_q <= '0;
      left_vld_q  <= 1'b0;
      audio0_q    <= '0;
      audio1_q    <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      idle_q      <= '0;
    end else begin
      state_q     <= state_d;
      left_hold_q <= left_hold_d;
      left_vld_q  <= left_vld_d;
      audio0_q    <= audio0_d;
      audio1_q    <= audio1_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      idle_q      <= idle_d;
    end
  end

  assign audio0_out    = audio0_q;
  assign audio1_out    = audio1_q;
  assign valid_out     = valid_q;
  assign frame_err_out = err_q;
  assign active_out    = (state_q != RX_HUNT);

endmodule
